// File: rtl/very_simple_switch.sv
// Per-port queuing FIFO for the simple switch datapath.
// Registered read port, occupancy count and status flags.
module very_simple_switch #(
  parameter int DWIDTH       = 64,
  parameter int AWIDTH       = 8,
  parameter int DEPTH        = 256,
  parameter int ALMOST_EMPTY = 1,
  parameter int ALMOST_FULL  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in,
  input  logic              push,
  input  logic              pop,
  output logic [DWIDTH-1:0] out,
  output logic              empty,
  output logic              almostempty,
  output logic              full,
  output logic              almostfull,
  output logic [AWIDTH:0]   num
);

  localparam int NW = AWIDTH + 1;

  localparam logic [AWIDTH:0] LVL_FULL = NW'(DEPTH);
  localparam logic [AWIDTH:0] LVL_AE   = NW'(ALMOST_EMPTY);
  localparam logic [AWIDTH:0] LVL_AF   = NW'(DEPTH - ALMOST_FULL);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  // acceptance uses the flags as they stand before the edge
  always_comb begin
    do_push = reset & push & ~full;
    do_pop  = reset & pop & ~empty;
  end

  // status flags decode straight from the occupancy count
  always_comb begin
    empty       = (num == '0);
    almostempty = (num <= LVL_AE);
    full        = (num == LVL_FULL);
    almostfull  = (num >= LVL_AF);
  end

  // storage array; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= in;
    end
  end

  // pointers, count and read register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      num    <= '0;
      out    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        out    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   num <= num + 1'b1;
        2'b01:   num <= num - 1'b1;
        default: num <= num;
      endcase
    end
  end

endmodule

// File: tb/tb_very_simple_switch.sv
// Randomized self-checking bench for very_simple_switch.
// Reference is a plain queue holding the FIFO contents.
module tb_very_simple_switch;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic [63:0] din;
  logic [63:0] dout;
  logic        empty;
  logic        almostempty;
  logic        full;
  logic        almostfull;
  logic [8:0]  num;

  logic [63:0] mq[$];
  logic [63:0] mout;
  int          passed;
  int          total;

  very_simple_switch dut (
    .clk         (clk),
    .reset       (reset),
    .in          (din),
    .push        (push),
    .pop         (pop),
    .out         (dout),
    .empty       (empty),
    .almostempty (almostempty),
    .full        (full),
    .almostfull  (almostfull),
    .num         (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".num"}, 64'(num), 64'(n));
    check({tag, ".empty"}, 64'(empty), 64'(n == 0));
    check({tag, ".aempty"}, 64'(almostempty), 64'(n <= 1));
    check({tag, ".full"}, 64'(full), 64'(n == 256));
    check({tag, ".afull"}, 64'(almostfull), 64'(n >= 255));
    check({tag, ".out"}, dout, mout);
  endtask

  task automatic model_reset();
    mq.delete();
    mout = '0;
  endtask

  task automatic step(input string tag, input logic p, input logic q,
                      input logic [63:0] d);
    bit pa;
    bit qa;
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    pa = p && (mq.size() < 256);
    qa = q && (mq.size() > 0);
    if (qa) mout = mq.pop_front();
    if (pa) mq.push_back(d);
    #1 check_all(tag);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    push   = 1'b0;
    pop    = 1'b0;
    din    = '0;
    model_reset();

    // reset held with a push pending
    #2;
    push  = 1'b1;
    din   = 64'd5;
    reset = 1'b0;
    #1 check_all("rst_imm");
    repeat (3) @(posedge clk);
    #1 check_all("rst_held");
    reset = 1'b1;
    step("first_push", 1'b1, 1'b0, 64'd5);

    // clean start for the fill
    reset = 1'b0;
    model_reset();
    #1 check_all("rst2");
    reset = 1'b1;

    for (int i = 0; i < 256; i++) step("fill", 1'b1, 1'b0, 64'(i));
    for (int i = 0; i < 10; i++) step("ovf", 1'b1, 1'b0, 64'd999);
    for (int i = 0; i < 256; i++) step("drain", 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step("udf", 1'b0, 1'b1, '0);

    // steady occupancy of 10 with both requests, wrapping pointers
    for (int i = 0; i < 10; i++)
      step("pre10", 1'b1, 1'b0, {$urandom, $urandom});
    for (int i = 0; i < 300; i++) step("both", 1'b1, 1'b1, 64'(i));
    for (int i = 0; i < 10; i++) step("drain10", 1'b0, 1'b1, '0);

    // both requests at the two extremes
    step("both_empty", 1'b1, 1'b1, 64'hABCD);
    for (int i = 0; i < 255; i++)
      step("refill", 1'b1, 1'b0, {$urandom, $urandom});
    step("both_full", 1'b1, 1'b1, 64'h1234);

    // down to 100 then reset between edges
    for (int i = 0; i < 155; i++) step("to100", 1'b0, 1'b1, '0);
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 check_all("mid_rst");
    #1 reset = 1'b1;
    step("post_push", 1'b1, 1'b0, 64'd7);
    step("post_pop", 1'b0, 1'b1, '0);

    // random traffic, first push-heavy then pop-heavy
    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = (i < 1500) ? 75 : 25;
      step("rand",
           ($urandom_range(99) < pw),
           ($urandom_range(99) >= pw),
           {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
